// File: rtl/game_flow_controller.sv
// game_flow_controller: game-state FSM for start, hits, level-ups and game over,
// timing the freeze, pause and game-over intervals in VGA frames.
module game_flow_controller #(
    parameter int                   NUM_LANES       = 4,
    parameter int                   C_FREEZE_FRAMES = 60,
    parameter int                   C_LEVEL_FRAMES  = 30,
    parameter int                   C_OVER_FRAMES   = 120,
    parameter logic [NUM_LANES-1:0] C_REVERSE_INI   = 4'b1010
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_All_Switch,
    input  logic                 i_Collision,
    input  logic                 i_Level_Up,
    input  logic                 i_Frame_Tick,
    input  logic [NUM_LANES-1:0] i_LFSR_Data,
    output logic                 o_Game_Active,
    output logic                 o_Freeze,
    output logic                 o_Frog_Reset,
    output logic [2:0]           o_Lives,
    output logic [3:0]           o_Score,
    output logic [NUM_LANES-1:0] o_Reverse,
    output logic [2:0]           o_Speed_Level,
    output logic [2:0]           o_State
);
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ARM         = 3'd1,
        RUNNING     = 3'd2,
        HIT_FREEZE  = 3'd3,
        LEVEL_PAUSE = 3'd4,
        GAME_OVER   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           lives_q, lives_d;
    logic [3:0]           score_q, score_d;
    logic [2:0]           speed_q, speed_d;
    logic [NUM_LANES-1:0] reverse_q, reverse_d;
    logic [7:0]           timer_q, timer_d;
    logic                 frog_q, frog_d;
    logic                 coll_q, lvl_q, freeze_q, active_q;
    logic                 coll_ev, lvl_ev;

    assign coll_ev = i_Collision & ~coll_q;
    assign lvl_ev  = i_Level_Up & ~lvl_q;

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        speed_d   = speed_q;
        reverse_d = reverse_q;
        timer_d   = timer_q;
        frog_d    = 1'b0;
        case (state_q)
            IDLE: if (i_All_Switch) begin
                lives_d   = 3'b111;
                score_d   = 4'd0;
                speed_d   = 3'd0;
                reverse_d = C_REVERSE_INI;
                frog_d    = 1'b1;
                state_d   = ARM;
            end
            ARM: if (!i_All_Switch) state_d = RUNNING;
            RUNNING: if (coll_ev) begin
                lives_d = lives_q >> 1;
                frog_d  = 1'b1;
                state_d = (lives_q == 3'b001) ? GAME_OVER : HIT_FREEZE;
                timer_d = (lives_q == 3'b001) ? 8'(C_OVER_FRAMES) : 8'(C_FREEZE_FRAMES);
            end else if (lvl_ev) begin
                score_d   = (score_q == 4'd9) ? 4'd0 : score_q + 4'd1;
                speed_d   = (speed_q == 3'd7) ? 3'd7 : speed_q + 3'd1;
                reverse_d = i_LFSR_Data;
                frog_d    = 1'b1;
                state_d   = LEVEL_PAUSE;
                timer_d   = 8'(C_LEVEL_FRAMES);
            end
            HIT_FREEZE, LEVEL_PAUSE, GAME_OVER: if (i_Frame_Tick) begin
                timer_d = timer_q - 8'd1;
                if (timer_q == 8'd1) state_d = (state_q == GAME_OVER) ? IDLE : RUNNING;
            end
            default: state_d = IDLE;
        endcase
    end

    // Active/freeze flags follow the next state so they line up with o_State.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q   <= IDLE;
            lives_q   <= 3'b000;
            score_q   <= 4'd0;
            speed_q   <= 3'd0;
            reverse_q <= C_REVERSE_INI;
            timer_q   <= 8'd0;
            frog_q    <= 1'b0;
            coll_q    <= 1'b0;
            lvl_q     <= 1'b0;
            freeze_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            speed_q   <= speed_d;
            reverse_q <= reverse_d;
            timer_q   <= timer_d;
            frog_q    <= frog_d;
            coll_q    <= i_Collision;
            lvl_q     <= i_Level_Up;
            freeze_q  <= (state_d == HIT_FREEZE) || (state_d == LEVEL_PAUSE);
            active_q  <= state_d == RUNNING;
        end
    end

    assign o_Game_Active = active_q;
    assign o_Freeze      = freeze_q;
    assign o_Frog_Reset  = frog_q;
    assign o_Lives       = lives_q;
    assign o_Score       = score_q;
    assign o_Reverse     = reverse_q;
    assign o_Speed_Level = speed_q;
    assign o_State       = state_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: scenario tasks with a queue of expected output snapshots
// {state, lives, score, speed, reverse, freeze, active}.
module tb_game_flow_controller;
    localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_RUN = 3'd2;
    localparam logic [2:0] S_HIT = 3'd3, S_LVL = 3'd4, S_OVR = 3'd5;
    localparam logic [3:0] REV_INI = 4'b1010;

    typedef logic [18:0] snap_t;

    logic       i_Clk = 1'b0, i_Rst_n = 1'b0, i_All_Switch = 1'b0;
    logic       i_Collision = 1'b0, i_Level_Up = 1'b0, i_Frame_Tick = 1'b0;
    logic [3:0] i_LFSR_Data = 4'b0000;
    logic       o_Game_Active, o_Freeze, o_Frog_Reset;
    logic [2:0] o_Lives, o_Speed_Level, o_State;
    logic [3:0] o_Score, o_Reverse;

    int    checks = 0, failures = 0, frog_cnt = 0;
    snap_t exp_q[$];
    snap_t s;

    game_flow_controller dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_All_Switch(i_All_Switch),
        .i_Collision(i_Collision), .i_Level_Up(i_Level_Up), .i_Frame_Tick(i_Frame_Tick),
        .i_LFSR_Data(i_LFSR_Data), .o_Game_Active(o_Game_Active), .o_Freeze(o_Freeze),
        .o_Frog_Reset(o_Frog_Reset), .o_Lives(o_Lives), .o_Score(o_Score),
        .o_Reverse(o_Reverse), .o_Speed_Level(o_Speed_Level), .o_State(o_State)
    );

    always #5 i_Clk = ~i_Clk;

    always @(negedge i_Clk) if (o_Frog_Reset) frog_cnt++;

    function automatic snap_t dut_snap();
        return {o_State, o_Lives, o_Score, o_Speed_Level, o_Reverse, o_Freeze, o_Game_Active};
    endfunction

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            i_Frame_Tick = 1'b1;
            step();
            i_Frame_Tick = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        i_Rst_n = 1'b0;
        exp_q.push_back({S_IDLE, 3'b000, 4'd0, 3'd0, REV_INI, 1'b0, 1'b0});
        step();
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", dut_snap(), s);
        end
        checks++;
        if (o_Frog_Reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_frog got=%b exp=0", o_Frog_Reset);
        end
    endtask

    task automatic test_start();
        int base;
        base = frog_cnt;
        i_Rst_n = 1'b1;
        i_All_Switch = 1'b1;
        exp_q.push_back({S_ARM, 3'b111, 4'd0, 3'd0, REV_INI, 1'b0, 1'b0});
        step();
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL start_arm got=%h exp=%h", dut_snap(), s);
        end
        step();
        step();
        exp_q.push_back({S_ARM, 3'b111, 4'd0, 3'd0, REV_INI, 1'b0, 1'b0});
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL start_hold_arm got=%h exp=%h", dut_snap(), s);
        end
        i_All_Switch = 1'b0;
        exp_q.push_back({S_RUN, 3'b111, 4'd0, 3'd0, REV_INI, 1'b0, 1'b1});
        step();
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL start_run got=%h exp=%h", dut_snap(), s);
        end
        checks++;
        if (frog_cnt - base !== 1) begin
            failures++;
            $display("FAIL start_frog_pulses got=%0d exp=1", frog_cnt - base);
        end
    endtask

    task automatic test_collision();
        int base;
        base = frog_cnt;
        i_Collision = 1'b1;
        exp_q.push_back({S_HIT, 3'b011, 4'd0, 3'd0, REV_INI, 1'b1, 1'b0});
        step();
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL hit1 got=%h exp=%h", dut_snap(), s);
        end
        tick_n(59);
        exp_q.push_back({S_HIT, 3'b011, 4'd0, 3'd0, REV_INI, 1'b1, 1'b0});
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL freeze_59 got=%h exp=%h", dut_snap(), s);
        end
        tick_n(1);
        step();
        step();
        exp_q.push_back({S_RUN, 3'b011, 4'd0, 3'd0, REV_INI, 1'b0, 1'b1});
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL held_no_loss got=%h exp=%h", dut_snap(), s);
        end
        i_Collision = 1'b0;
        step();
        i_Collision = 1'b1;
        exp_q.push_back({S_HIT, 3'b001, 4'd0, 3'd0, REV_INI, 1'b1, 1'b0});
        step();
        i_Collision = 1'b0;
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL hit2 got=%h exp=%h", dut_snap(), s);
        end
        tick_n(60);
        exp_q.push_back({S_RUN, 3'b001, 4'd0, 3'd0, REV_INI, 1'b0, 1'b1});
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL resume2 got=%h exp=%h", dut_snap(), s);
        end
        i_Collision = 1'b1;
        exp_q.push_back({S_OVR, 3'b000, 4'd0, 3'd0, REV_INI, 1'b0, 1'b0});
        step();
        i_Collision = 1'b0;
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL hit3_over got=%h exp=%h", dut_snap(), s);
        end
        tick_n(119);
        exp_q.push_back({S_OVR, 3'b000, 4'd0, 3'd0, REV_INI, 1'b0, 1'b0});
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL over_hold got=%h exp=%h", dut_snap(), s);
        end
        tick_n(1);
        exp_q.push_back({S_IDLE, 3'b000, 4'd0, 3'd0, REV_INI, 1'b0, 1'b0});
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL over_idle got=%h exp=%h", dut_snap(), s);
        end
        checks++;
        if (frog_cnt - base !== 3) begin
            failures++;
            $display("FAIL hit_frog_pulses got=%0d exp=3", frog_cnt - base);
        end
    endtask

    task automatic test_level();
        logic [3:0] sc;
        logic [2:0] sp;
        i_LFSR_Data = 4'b0110;
        i_All_Switch = 1'b1;
        step();
        i_All_Switch = 1'b0;
        step();
        for (int k = 1; k <= 10; k++) begin
            sc = 4'(k % 10);
            sp = (k < 7) ? 3'(k) : 3'd7;
            i_Level_Up = 1'b1;
            exp_q.push_back({S_LVL, 3'b111, sc, sp, 4'b0110, 1'b1, 1'b0});
            step();
            i_Level_Up = 1'b0;
            s = exp_q.pop_front();
            checks++;
            if (dut_snap() !== s) begin
                failures++;
                $display("FAIL level%0d_enter got=%h exp=%h", k, dut_snap(), s);
            end
            if (k == 1) begin
                i_Collision = 1'b1;
                step();
                i_Collision = 1'b0;
            end
            tick_n(29);
            exp_q.push_back({S_LVL, 3'b111, sc, sp, 4'b0110, 1'b1, 1'b0});
            s = exp_q.pop_front();
            checks++;
            if (dut_snap() !== s) begin
                failures++;
                $display("FAIL level%0d_pause got=%h exp=%h", k, dut_snap(), s);
            end
            tick_n(1);
            exp_q.push_back({S_RUN, 3'b111, sc, sp, 4'b0110, 1'b0, 1'b1});
            s = exp_q.pop_front();
            checks++;
            if (dut_snap() !== s) begin
                failures++;
                $display("FAIL level%0d_resume got=%h exp=%h", k, dut_snap(), s);
            end
        end
    endtask

    task automatic test_simultaneous();
        i_Collision = 1'b1;
        i_Level_Up = 1'b1;
        exp_q.push_back({S_HIT, 3'b011, 4'd0, 3'd7, 4'b0110, 1'b1, 1'b0});
        step();
        i_Collision = 1'b0;
        i_Level_Up = 1'b0;
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL simultaneous got=%h exp=%h", dut_snap(), s);
        end
    endtask

    task automatic test_reset_mid();
        tick_n(30);
        exp_q.push_back({S_HIT, 3'b011, 4'd0, 3'd7, 4'b0110, 1'b1, 1'b0});
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL mid_freeze got=%h exp=%h", dut_snap(), s);
        end
        i_Rst_n = 1'b0;
        exp_q.push_back({S_IDLE, 3'b000, 4'd0, 3'd0, REV_INI, 1'b0, 1'b0});
        step();
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", dut_snap(), s);
        end
        checks++;
        if (o_Frog_Reset !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_frog got=%b exp=0", o_Frog_Reset);
        end
        i_Rst_n = 1'b1;
        tick_n(2);
        exp_q.push_back({S_IDLE, 3'b000, 4'd0, 3'd0, REV_INI, 1'b0, 1'b0});
        s = exp_q.pop_front();
        checks++;
        if (dut_snap() !== s) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=%h", dut_snap(), s);
        end
    endtask

    initial begin
        step();
        test_reset();
        test_start();
        test_collision();
        test_level();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/game_flow_controller.md
GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of car lanes / width of the reverse mask.
REQ-002 SHALL have parameter C_FREEZE_FRAMES, default 60, frames held frozen after a hit (1..255).
REQ-003 SHALL have parameter C_LEVEL_FRAMES, default 30, frames paused after a level-up (1..255).
REQ-004 SHALL have parameter C_OVER_FRAMES, default 120, frames spent in GAME_OVER before returning to IDLE (1..255).
REQ-005 SHALL have parameter C_REVERSE_INI, default 4'b1010, reverse mask loaded at game start.
REQ-006 SHALL have port i_Clk  input  1  system clock; the only clock.
REQ-007 SHALL have port i_Rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port i_All_Switch  input  1  debounced AND of all four switches; the start request.
REQ-009 SHALL have port i_Collision  input  1  level, frog/car overlap.
REQ-010 SHALL have port i_Level_Up  input  1  level, frog reached the top row.
REQ-011 SHALL have port i_Frame_Tick  input  1  one-cycle pulse per VGA frame; the timebase for all timers.
REQ-012 SHALL have port i_LFSR_Data  input  NUM_LANES  pseudo-random lane-direction sample.
REQ-013 SHALL have port o_Game_Active  output  1  high only in RUNNING.
REQ-014 SHALL have port o_Freeze  output  1  high in HIT_FREEZE and LEVEL_PAUSE; freezes car movement.
REQ-015 SHALL have port o_Frog_Reset  output  1  one-cycle pulse returning the frog to its base position.
REQ-016 SHALL have port o_Lives  output  3  thermometer lives count, drives the LEDs.
REQ-017 SHALL have port o_Score  output  4  levels cleared, 0..9.
REQ-018 SHALL have port o_Reverse  output  NUM_LANES  per-lane direction mask sent to obstacle movement.
REQ-019 SHALL have port o_Speed_Level  output  3  car speed index, 0..7.
REQ-020 SHALL have port o_State  output  3  state encoding, for debug.

Function
REQ-021 SHALL implement states IDLE=0, ARM=1, RUNNING=2, HIT_FREEZE=3, LEVEL_PAUSE=4, GAME_OVER=5; encodings 6 and 7 SHALL go to IDLE on the next cycle.
REQ-022 SHALL register i_Collision and i_Level_Up; an event is a rising edge (current 1, previous 0), detected in all states and acted on only in RUNNING.
REQ-023 In IDLE, when i_All_Switch=1, the block SHALL, in the same cycle: load lives 3'b111, score 0, speed 0 and reverse C_REVERSE_INI; pulse o_Frog_Reset; and go to ARM.
REQ-024 In ARM, the block SHALL wait for i_All_Switch=0 and then go to RUNNING, so that the start press does not move the frog.
REQ-025 In RUNNING, a collision event SHALL shift lives right by 1 and pulse o_Frog_Reset; if lives was 3'b001, the block SHALL go to GAME_OVER with timer=C_OVER_FRAMES, otherwise to HIT_FREEZE with timer=C_FREEZE_FRAMES.
REQ-026 In RUNNING, a level-up event SHALL increment score, wrapping 9->0; SHALL increment speed, saturating at 7; SHALL load o_Reverse from i_LFSR_Data; SHALL pulse o_Frog_Reset; and SHALL go to LEVEL_PAUSE with timer=C_LEVEL_FRAMES.
REQ-027 If a collision event and a level-up event occur in the same cycle, the collision SHALL win and the level-up SHALL be discarded.
REQ-028 In HIT_FREEZE, LEVEL_PAUSE and GAME_OVER, the 8-bit timer SHALL decrement only on i_Frame_Tick; a tick while timer=1 SHALL exit the state (to RUNNING, RUNNING and IDLE respectively) on the following cycle.
REQ-029 Events arriving during HIT_FREEZE, LEVEL_PAUSE, GAME_OVER, IDLE or ARM SHALL be ignored; score, lives and reverse SHALL hold.
REQ-030 In GAME_OVER, o_Score and o_Lives SHALL hold their final values (lives=0) until the next IDLE start.
REQ-031 o_Frog_Reset SHALL be exactly one cycle wide and registered; all outputs SHALL be registered.

Reset
REQ-032 With i_Rst_n=0 at a clock edge, the block SHALL give: state IDLE, lives 3'b000, score 0, speed 0, reverse C_REVERSE_INI, timer 0, o_Frog_Reset 0, o_Freeze 0, o_Game_Active 0, and edge registers 0.
REQ-033 Reset SHALL take priority over every event and SHALL abort any state or timer mid-count.

Verification
REQ-034 Reset, then i_All_Switch=1 for 3 cycles, then 0 -> ARM, then RUNNING; o_Lives=111, o_Frog_Reset exactly one pulse, o_Game_Active=1.
REQ-035 Three collision rising edges, each after its freeze expires -> o_Lives 011, 001, 000; third edge -> GAME_OVER; C_OVER_FRAMES ticks later -> IDLE.
REQ-036 Collision held high across the freeze -> no second life lost on re-entering RUNNING.
REQ-037 Ten level-ups with i_LFSR_Data=4'b0110 -> score wraps to 0, speed=7, o_Reverse=0110, o_Freeze high C_LEVEL_FRAMES ticks each.
REQ-038 Collision and level-up rising in the same cycle -> lives decremented, score unchanged, state HIT_FREEZE.
REQ-039 i_Rst_n=0 mid-HIT_FREEZE with timer=30 -> next cycle IDLE, all outputs at REQ-032 values.
